// File: rtl/multicyc_mcu.sv
// Main control FSM for the multicycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// and emits per-state control, with handshake or fixed-latency memory stalls and illegal-opcode trap.
module multicyc_mcu #(
  parameter int HANDSHAKE = 1,
  parameter int MEM_LAT   = 1,
  parameter int ILL_HALT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       is_beq,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       wreg_dst_sel,
  output logic       wrbck_sel,
  output logic       reg_we,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RR    = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RR   = 2'b10;
  localparam logic [1:0] ALU_ADDU = 2'b11;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          in_mem, done, pcwrite_q;

  assign in_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign done    = in_mem && ((HANDSHAKE != 0) ? mem_ready : (cnt == CNT_LAST));
  assign state_o = state;

  // IR/PC update must land on the completing fetch cycle, which is only known this cycle
  assign irwrite = (state == S_FETCH) && done;
  assign pcwrite = pcwrite_q || ((state == S_FETCH) && done);

  always_comb begin
    nxt = state;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  if (done) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RR:              nxt = S_EXEC;
          OP_LW, OP_SW:       nxt = S_MEMADR;
          OP_BEQ:             nxt = S_BRANCH;
          OP_J:               nxt = S_JUMP;
          OP_ADDI, OP_ADDIU:  nxt = S_ADDIEX;
          default:            nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (done) nxt = S_MEMWB;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   if (done) nxt = S_FETCH;
      S_EXEC:    nxt = S_ALUWB;
      S_ALUWB:   nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ADDIWB:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_ILLEGAL: nxt = (ILL_HALT != 0) ? S_ILLEGAL : S_FETCH;
      default:   nxt = S_RST;
    endcase
  end

  // Control outputs are registered from the next state so they are glitch-free Moore signals
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RST;
      cnt          <= '0;
      illegal      <= 1'b0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      iord         <= 1'b0;
      pcwrite_q    <= 1'b0;
      is_beq       <= 1'b0;
      alusrca      <= 1'b0;
      alusrcb      <= 2'b00;
      wreg_dst_sel <= 1'b0;
      wrbck_sel    <= 1'b0;
      reg_we       <= 1'b0;
      pcsrc        <= 2'b00;
      aluop        <= ALU_ADD;
    end else begin
      state <= nxt;
      // counter is zero on entry to every memory state because it clears on done
      if (in_mem && !done) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
      if (nxt == S_ILLEGAL) illegal <= 1'b1;

      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      iord         <= 1'b0;
      pcwrite_q    <= 1'b0;
      is_beq       <= 1'b0;
      alusrca      <= 1'b0;
      alusrcb      <= 2'b00;
      wreg_dst_sel <= 1'b0;
      wrbck_sel    <= 1'b0;
      reg_we       <= 1'b0;
      pcsrc        <= 2'b00;
      aluop        <= ALU_ADD;
      case (nxt)
        S_FETCH: begin
          mem_req <= 1'b1;
          alusrcb <= 2'b01;
        end
        S_DECODE: alusrcb <= 2'b11;
        S_MEMADR: begin
          alusrca <= 1'b1;
          alusrcb <= 2'b10;
        end
        S_MEMRD: begin
          mem_req <= 1'b1;
          iord    <= 1'b1;
        end
        S_MEMWB: begin
          reg_we    <= 1'b1;
          wrbck_sel <= 1'b1;
        end
        S_MEMWR: begin
          mem_req <= 1'b1;
          mem_wr  <= 1'b1;
          iord    <= 1'b1;
        end
        S_EXEC: begin
          alusrca <= 1'b1;
          aluop   <= ALU_RR;
        end
        S_ALUWB: begin
          reg_we       <= 1'b1;
          wreg_dst_sel <= 1'b1;
        end
        S_BRANCH: begin
          alusrca <= 1'b1;
          aluop   <= ALU_SUB;
          is_beq  <= 1'b1;
          pcsrc   <= 2'b01;
        end
        S_ADDIEX: begin
          alusrca <= 1'b1;
          alusrcb <= 2'b10;
          aluop   <= (opcode == OP_ADDIU) ? ALU_ADDU : ALU_ADD;
        end
        S_ADDIWB: reg_we <= 1'b1;
        S_JUMP: begin
          pcwrite_q <= 1'b1;
          pcsrc     <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicyc_mcu.sv
// Scoreboard bench for multicyc_mcu: a handshake/halting instance and a fixed-latency (3)/non-halting
// instance; per-cycle expected control words are queued with the stimulus and compared each cycle.
module tb_multicyc_mcu;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_wr, iord, irwrite, pcwrite, is_beq, alusrca;
    logic [1:0] alusrcb;
    logic       wreg_dst_sel, wrbck_sel, reg_we;
    logic [1:0] pcsrc, aluop;
    logic       illegal;
  } obs_t;

  localparam logic [3:0] RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5,
    MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, ADDIEX = 10, ADDIWB = 11, JUMP = 12, ILLEGAL = 13;
  localparam int LAT = 3;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;
  always #5 clk = ~clk;

  logic h_mem_req, h_mem_wr, h_iord, h_irwrite, h_pcwrite, h_is_beq, h_alusrca, h_wreg, h_wrbck, h_reg_we, h_ill;
  logic [1:0] h_alusrcb, h_pcsrc, h_aluop;
  logic [3:0] h_st;
  logic l_mem_req, l_mem_wr, l_iord, l_irwrite, l_pcwrite, l_is_beq, l_alusrca, l_wreg, l_wrbck, l_reg_we, l_ill;
  logic [1:0] l_alusrcb, l_pcsrc, l_aluop;
  logic [3:0] l_st;

  multicyc_mcu #(.HANDSHAKE(1), .MEM_LAT(1), .ILL_HALT(1)) dut_hs (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .mem_wr(h_mem_wr), .iord(h_iord), .irwrite(h_irwrite), .pcwrite(h_pcwrite),
    .is_beq(h_is_beq), .alusrca(h_alusrca), .alusrcb(h_alusrcb), .wreg_dst_sel(h_wreg),
    .wrbck_sel(h_wrbck), .reg_we(h_reg_we), .pcsrc(h_pcsrc), .aluop(h_aluop), .illegal(h_ill),
    .state_o(h_st));

  multicyc_mcu #(.HANDSHAKE(0), .MEM_LAT(LAT), .ILL_HALT(0)) dut_lt (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(l_mem_req), .mem_wr(l_mem_wr), .iord(l_iord), .irwrite(l_irwrite), .pcwrite(l_pcwrite),
    .is_beq(l_is_beq), .alusrca(l_alusrca), .alusrcb(l_alusrcb), .wreg_dst_sel(l_wreg),
    .wrbck_sel(l_wrbck), .reg_we(l_reg_we), .pcsrc(l_pcsrc), .aluop(l_aluop), .illegal(l_ill),
    .state_o(l_st));

  obs_t obs_hs, obs_lt, obs;
  int   sel = 0;
  assign obs_hs = {h_st, h_mem_req, h_mem_wr, h_iord, h_irwrite, h_pcwrite, h_is_beq, h_alusrca,
                   h_alusrcb, h_wreg, h_wrbck, h_reg_we, h_pcsrc, h_aluop, h_ill};
  assign obs_lt = {l_st, l_mem_req, l_mem_wr, l_iord, l_irwrite, l_pcwrite, l_is_beq, l_alusrca,
                   l_alusrcb, l_wreg, l_wrbck, l_reg_we, l_pcsrc, l_aluop, l_ill};
  assign obs = (sel == 0) ? obs_hs : obs_lt;

  int   n_vec = 0, n_miss = 0;
  obs_t exp_q[$];
  logic stim_q[$];
  string tag_q[$];
  logic ill_m = 1'b0;

  task automatic check_vec(input string tag, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got st=%0d ctrl=%h, want st=%0d ctrl=%h", tag, got.st, got[16:0], want.st, want[16:0]);
    end
  endtask

  // Expected control word for a state, written straight from the state/control table
  function automatic obs_t ev(input logic [3:0] st, input logic [5:0] op, input logic fdone, input logic ill);
    obs_t o = '0;
    o.st = st;
    o.illegal = ill;
    case (st)
      FETCH:  begin o.mem_req = 1; o.alusrcb = 2'b01; o.irwrite = fdone; o.pcwrite = fdone; end
      DECODE: o.alusrcb = 2'b11;
      MEMADR: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      MEMRD:  begin o.mem_req = 1; o.iord = 1; end
      MEMWB:  begin o.reg_we = 1; o.wrbck_sel = 1; end
      MEMWR:  begin o.mem_req = 1; o.mem_wr = 1; o.iord = 1; end
      EXEC:   begin o.alusrca = 1; o.aluop = 2'b10; end
      ALUWB:  begin o.reg_we = 1; o.wreg_dst_sel = 1; end
      BRANCH: begin o.alusrca = 1; o.aluop = 2'b01; o.is_beq = 1; o.pcsrc = 2'b01; end
      ADDIEX: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = (op == 6'h09) ? 2'b11 : 2'b00; end
      ADDIWB: o.reg_we = 1;
      JUMP:   begin o.pcwrite = 1; o.pcsrc = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input string tag, input logic [3:0] st, input logic fdone, input logic mr);
    exp_q.push_back(ev(st, opcode, fdone, ill_m));
    stim_q.push_back(mr);
    tag_q.push_back(tag);
  endtask

  // Memory state: handshake instance stalls mst cycles; latency instance always LAT cycles with mem_ready noise
  task automatic push_mem(input string tag, input logic [3:0] st, input int mst);
    int ns = (sel == 0) ? mst : LAT - 1;
    for (int i = 0; i < ns; i++) push(tag, st, 1'b0, (sel == 0) ? 1'b0 : 1'($urandom_range(1)));
    push(tag, st, 1'b1, 1'b1);
  endtask

  task automatic run_q();
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1 mem_ready = stim_q.pop_front();
      @(negedge clk);
      check_vec(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input int fst, input int mst, input int extra_ill);
    opcode = op;
    push_mem({tag, "_fetch"}, FETCH, fst);
    push({tag, "_decode"}, DECODE, 1'b0, 1'($urandom_range(1)));
    case (op)
      6'h23: begin
        push({tag, "_memadr"}, MEMADR, 1'b0, 1'b1);
        push_mem({tag, "_memrd"}, MEMRD, mst);
        push({tag, "_memwb"}, MEMWB, 1'b0, 1'b1);
      end
      6'h2B: begin
        push({tag, "_memadr"}, MEMADR, 1'b0, 1'b1);
        push_mem({tag, "_memwr"}, MEMWR, mst);
      end
      6'h00: begin
        push({tag, "_exec"}, EXEC, 1'b0, 1'b1);
        push({tag, "_aluwb"}, ALUWB, 1'b0, 1'b1);
      end
      6'h04: push({tag, "_branch"}, BRANCH, 1'b0, 1'b1);
      6'h02: push({tag, "_jump"}, JUMP, 1'b0, 1'b1);
      6'h08, 6'h09: begin
        push({tag, "_addiex"}, ADDIEX, 1'b0, 1'b1);
        push({tag, "_addiwb"}, ADDIWB, 1'b0, 1'b1);
      end
      default: begin
        ill_m = 1'b1;
        push({tag, "_illegal"}, ILLEGAL, 1'b0, 1'b1);
        for (int i = 0; i < extra_ill; i++) push({tag, "_ill_hold"}, ILLEGAL, 1'b0, 1'b1);
      end
    endcase
    run_q();
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    sel = which;
    rst = 1'b1;
    mem_ready = 1'b1;
    ill_m = 1'b0;
    @(negedge clk);
    check_vec("reset", obs, ev(RST, opcode, 1'b0, 1'b0));
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Handshake / halting instance
    do_reset(0);
    do_instr("hs_lw", 6'h23, 0, 0, 0);
    do_instr("hs_lw_stall", 6'h23, 3, 2, 0);
    do_instr("hs_sw", 6'h2B, 0, 1, 0);
    do_instr("hs_rr", 6'h00, 0, 0, 0);
    do_instr("hs_beq", 6'h04, 1, 0, 0);
    do_instr("hs_j", 6'h02, 0, 0, 0);
    do_instr("hs_addi", 6'h08, 0, 0, 0);
    do_instr("hs_addiu", 6'h09, 2, 0, 0);
    do_instr("hs_ill", 6'h3F, 0, 0, 4);
    do_reset(0);
    do_instr("hs_after_ill", 6'h02, 0, 0, 0);

    // Reset pulsed in the middle of a MEMWR stall drops the store immediately
    do_reset(0);
    opcode = 6'h2B;
    push("rs_fetch", FETCH, 1'b1, 1'b1);
    push("rs_decode", DECODE, 1'b0, 1'b0);
    push("rs_memadr", MEMADR, 1'b0, 1'b0);
    push("rs_memwr", MEMWR, 1'b0, 1'b0);
    push("rs_memwr", MEMWR, 1'b0, 1'b0);
    run_q();
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_vec("rst_async", obs, ev(RST, opcode, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    push("rs_refetch", FETCH, 1'b0, 1'b0);
    push("rs_refetch_done", FETCH, 1'b1, 1'b1);
    run_q();

    // Fixed-latency / non-halting instance
    do_reset(1);
    do_instr("lt_sw", 6'h2B, 0, 0, 0);
    do_instr("lt_lw", 6'h23, 0, 0, 0);
    do_instr("lt_addiu", 6'h09, 0, 0, 0);
    do_instr("lt_rr", 6'h00, 0, 0, 0);
    do_instr("lt_ill", 6'h3F, 0, 0, 0);
    do_instr("lt_j_sticky", 6'h02, 0, 0, 0);
    do_instr("lt_beq_sticky", 6'h04, 0, 0, 0);
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
